// File: rtl/led_pkg.sv
// Shared types and helpers for the LED strip transmit path.
// Pixels are stored as {R,G,B}; the wire order is G,R,B.
package led_pkg;

    localparam int DEF_NUM_LEDS = 10;

    localparam int R_MSB = 23;
    localparam int G_MSB = 15;
    localparam int B_MSB = 7;

    typedef logic [23:0] pixel_t;
    typedef pixel_t [DEF_NUM_LEDS-1:0] strip_t;
    typedef logic [2:0] brightness_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BIT_HI,
        BIT_LO,
        LATCH
    } ser_state_t;

    // (c * (b+1)) >> 3; the 11-bit product never overflows
    function automatic logic [7:0] scale_ch(
        input logic [7:0] c,
        input brightness_t b
    );
        logic [10:0] p;
        p = {3'b000, c} * ({8'h00, b} + 11'd1);
        return p[10:3];
    endfunction

endpackage

// File: rtl/led_pixel_scaler.sv
// Scales one {R,G,B} pixel by brightness.
// The result is reordered to GRB, ready for MSB-first shifting.
module led_pixel_scaler
    import led_pkg::*;
(
    input  pixel_t      pixel,
    input  brightness_t brightness,
    output logic [23:0] grb
);

    assign grb = {
        scale_ch(pixel[G_MSB -: 8], brightness),
        scale_ch(pixel[R_MSB -: 8], brightness),
        scale_ch(pixel[B_MSB -: 8], brightness)
    };

endmodule

// File: rtl/led_strip_serializer.sv
// Frame snapshot, brightness scaling and WS2812-style pulse-width
// serialization of a full strip, followed by the latch gap.
module led_strip_serializer
    import led_pkg::*;
#(
    parameter int NUM_LEDS  = 10,
    parameter int T0H_CYC   = 20,
    parameter int T1H_CYC   = 40,
    parameter int BIT_CYC   = 63,
    parameter int RESET_CYC = 2500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  pixel_t [NUM_LEDS-1:0]   strip,
    input  brightness_t             brightness,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    output logic                    dout,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int CMAX = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int LW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [CW-1:0] HI0  = CW'(T0H_CYC - 1);
    localparam logic [CW-1:0] HI1  = CW'(T1H_CYC - 1);
    localparam logic [CW-1:0] BEND = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] LEND = CW'(RESET_CYC);
    localparam logic [LW-1:0] LAST = LW'(NUM_LEDS - 1);

    if (!(T0H_CYC >= 1 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC)) begin : g_bad_timing
        $error("led_strip_serializer: need 1 <= T0H_CYC < T1H_CYC < BIT_CYC");
    end
    if (NUM_LEDS < 1) begin : g_bad_leds
        $error("led_strip_serializer: NUM_LEDS must be >= 1");
    end

    ser_state_t            state;
    pixel_t [NUM_LEDS-1:0] snap;
    brightness_t           bri;
    logic [23:0]           shreg;
    logic [4:0]            bitn;
    logic [LW-1:0]         led;
    logic [CW-1:0]         cnt;
    logic [LW-1:0]         sel;
    logic [23:0]           grb;

    assign frame_ready = (state == IDLE);

    // Scaler always looks at the pixel that will be loaded next
    assign sel = (state == LOAD || led == LAST) ? '0 : led + LW'(1);

    led_pixel_scaler u_scaler (
        .pixel      (snap[sel]),
        .brightness (bri),
        .grb        (grb)
    );

    // dout is a registered copy of the bit phase, one cycle behind state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            snap       <= '0;
            bri        <= '0;
            shreg      <= '0;
            bitn       <= '0;
            led        <= '0;
            cnt        <= '0;
            dout       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    dout <= 1'b0;
                    busy <= 1'b0;
                    if (frame_valid) begin
                        snap  <= strip;
                        bri   <= brightness;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shreg <= grb;
                    led   <= '0;
                    bitn  <= 5'd23;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= BIT_HI;
                end
                BIT_HI: begin
                    dout <= 1'b1;
                    cnt  <= cnt + CW'(1);
                    if (cnt == (shreg[23] ? HI1 : HI0))
                        state <= BIT_LO;
                end
                BIT_LO: begin
                    dout <= 1'b0;
                    if (cnt == BEND) begin
                        cnt <= '0;
                        if (bitn != 5'd0) begin
                            shreg <= {shreg[22:0], 1'b0};
                            bitn  <= bitn - 5'd1;
                            state <= BIT_HI;
                        end else if (led == LAST) begin
                            state <= LATCH;
                        end else begin
                            shreg <= grb;
                            led   <= led + LW'(1);
                            bitn  <= 5'd23;
                            state <= BIT_HI;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                LATCH: begin
                    dout <= 1'b0;
                    if (cnt == LEND) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_strip_serializer.sv
// Scoreboard bench: stimulus queues expected GRB words, a dout
// decoder on the falling clock edge recovers and compares them.
module tb_led_strip_serializer;

    localparam int NL = 2;
    localparam int T0 = 2;
    localparam int T1 = 5;
    localparam int BC = 8;
    localparam int RC = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NL-1:0][23:0]  strip = '0;
    logic [2:0]           brightness = '0;
    logic                 frame_valid = 1'b0;
    logic                 frame_ready;
    logic                 dout;
    logic                 busy;
    logic                 frame_done;

    always #5 clk = ~clk;

    led_strip_serializer #(
        .NUM_LEDS  (NL),
        .T0H_CYC   (T0),
        .T1H_CYC   (T1),
        .BIT_CYC   (BC),
        .RESET_CYC (RC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .strip       (strip),
        .brightness  (brightness),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .dout        (dout),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    int          nvec = 0;
    int          nerr = 0;
    int          exp_frames = 0;
    int          done_cnt = 0;
    logic [23:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] sc(input logic [7:0] c, input logic [2:0] b);
        int v;
        v = (int'(c) * (int'(b) + 1)) / 8;
        return v[7:0];
    endfunction

    function automatic logic [23:0] model(input logic [23:0] p, input logic [2:0] b);
        return {sc(p[15:8], b), sc(p[23:16], b), sc(p[7:0], b)};
    endfunction

    // Line decoder
    initial begin : mon
        int          hi;
        int          lo;
        int          gap;
        int          nb;
        logic        inb;
        logic [23:0] w;
        logic [23:0] e;
        hi = 0; lo = 0; gap = 0; nb = 0; inb = 1'b0; w = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hi = 0; lo = 0; gap = 0; nb = 0; inb = 1'b0; w = '0;
            end else begin
                if (frame_done) begin
                    done_cnt++;
                    chk("latch_gap", gap, RC);
                    chk("frame_bits_left", nb, 0);
                end
                if (dout) begin
                    if (inb && lo != 0) begin
                        chk("bit_period", hi + lo, BC);
                        inb = 1'b0;
                    end
                    if (!inb) begin
                        inb = 1'b1; hi = 0; lo = 0;
                    end
                    hi++;
                end else if (inb) begin
                    lo++;
                    if (hi + lo == BC) begin
                        chk("high_width_legal", (hi == T0 || hi == T1), 1);
                        w = {w[22:0], (hi == T1)};
                        nb++;
                        inb = 1'b0;
                        gap = 0;
                        if (nb == 24) begin
                            nb = 0;
                            if (exp_q.size() == 0) begin
                                chk("unexpected_word", exp_q.size(), 1);
                            end else begin
                                e = exp_q.pop_front();
                                chk("grb_word", w, e);
                            end
                        end
                    end
                end else begin
                    gap++;
                end
            end
        end
    end

    task automatic wait_ready();
        int t;
        t = 0;
        @(negedge clk);
        while (!frame_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("ready_timeout", frame_ready, 1);
    endtask

    task automatic start(input logic [23:0] p0, input logic [23:0] p1, input logic [2:0] b,
                         input logic [23:0] e0, input logic [23:0] e1);
        wait_ready();
        strip[0] = p0;
        strip[1] = p1;
        brightness = b;
        frame_valid = 1'b1;
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        exp_frames++;
        @(posedge clk);
        #1 frame_valid = 1'b0;
    endtask

    // Cycle indices are counted from the handshake edge
    task automatic measure(output int rise, output int done, output int blast);
        rise = -1; done = -1; blast = -1;
        for (int k = 1; k <= 3000 && done < 0; k++) begin
            @(posedge clk);
            #1;
            if (dout && rise < 0) rise = k;
            if (busy) blast = k;
            if (frame_done) done = k;
        end
    endtask

    initial begin : stim
        int          r;
        int          d;
        int          bl;
        int          t;
        logic [23:0] a;
        logic [23:0] c;
        logic [2:0]  b;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        repeat (50) begin
            @(negedge clk);
            chk("idle_dout", dout, 0);
            chk("idle_busy", busy, 0);
            chk("idle_ready", frame_ready, 1);
            chk("idle_done", frame_done, 0);
        end

        start(24'hFF0000, 24'h0000FF, 3'd7, 24'h00FF00, 24'h0000FF);
        measure(r, d, bl);
        chk("first_rise", r, 2);
        chk("done_cycle", d, 402);
        chk("busy_last", bl, 401);

        start(24'hFFFFFF, 24'hFFFFFF, 3'd3, 24'h7F7F7F, 24'h7F7F7F);
        measure(r, d, bl);
        chk("b3_done_cycle", d, 402);
        start(24'hFFFFFF, 24'hFFFFFF, 3'd0, 24'h1F1F1F, 24'h1F1F1F);
        measure(r, d, bl);
        chk("b0_done_cycle", d, 402);

        wait_ready();
        strip[0] = 24'h123456;
        strip[1] = 24'hABCDEF;
        brightness = 3'd5;
        frame_valid = 1'b1;
        exp_q.push_back(24'h270D40);
        exp_q.push_back(24'h9980B3);
        exp_frames++;
        @(posedge clk);
        t = 0;
        do begin
            @(negedge clk);
            if (!frame_ready) begin
                strip[0] = 24'($urandom());
                strip[1] = 24'($urandom());
                brightness = 3'($urandom_range(0, 7));
            end
            t++;
        end while (!frame_ready && t < 3000);
        chk("b2b_done_with_ready", frame_done, 1);
        strip[0] = 24'h00FF80;
        strip[1] = 24'h804020;
        brightness = 3'd1;
        exp_q.push_back(24'h3F0020);
        exp_q.push_back(24'h102008);
        exp_frames++;
        @(posedge clk);
        #1 frame_valid = 1'b0;
        measure(r, d, bl);
        chk("b2b_first_rise", r, 2);
        chk("b2b_done_cycle", d, 402);

        start(24'hA5C3F0, 24'h0F0F0F, 3'd7, 24'hC3A5F0, 24'h0F0F0F);
        repeat (106) @(posedge clk);
        #2;
        chk("pre_reset_high", dout, 1);
        rst_n = 1'b0;
        #1;
        chk("async_dout_low", dout, 0);
        chk("async_busy_low", busy, 0);
        chk("async_ready", frame_ready, 1);
        exp_q.delete();
        exp_frames--;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        start(24'hA5C3F0, 24'h0F0F0F, 3'd2, 24'h493D5A, 24'h050505);
        measure(r, d, bl);
        chk("post_reset_rise", r, 2);
        chk("post_reset_done", d, 402);

        for (int i = 0; i < 20; i++) begin
            a = 24'($urandom());
            c = 24'($urandom());
            b = 3'($urandom_range(0, 7));
            start(a, c, b, model(a, b), model(c, b));
            measure(r, d, bl);
            chk("rand_done_cycle", d, 402);
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("frame_done_count", done_cnt, exp_frames);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
